// File: rtl/aes_pkg.sv
// Shared constants and types for the AES round-key controller and its store.
package aes_pkg;

    localparam int unsigned KEY_LEN       = 128;
    localparam int unsigned NUMS_OF_ROUND = 10;
    localparam int unsigned RK_IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2,
        ERROR  = 2'd3
    } state_t;

    typedef logic [KEY_LEN-1:0] round_key_t;

    function automatic logic idx_in_range(input logic [RK_IDX_W-1:0] idx);
        return idx <= RK_IDX_W'(NUMS_OF_ROUND);
    endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: entry 0 holds the original key, 1..N the expanded keys.
module aes_rk_store
    import aes_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_clr,
    input  logic                             i_wr0_en,
    input  logic [KEY_LEN-1:0]               i_wr0_data,
    input  logic                             i_bulk_en,
    input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] i_bulk_data,
    input  logic                             i_rd_en,
    input  logic [RK_IDX_W-1:0]              i_rd_idx,
    output logic [KEY_LEN-1:0]               o_rd_data
);

    round_key_t r_mem [0:NUMS_OF_ROUND];
    round_key_t r_rd_data;

    // Out-of-range reads return zero; the read register holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NUMS_OF_ROUND); i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else if (i_clr) begin
            for (int i = 0; i <= int'(NUMS_OF_ROUND); i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr0_en) begin
                r_mem[0] <= i_wr0_data;
            end
            if (i_bulk_en) begin
                for (int i = 1; i <= int'(NUMS_OF_ROUND); i++) begin
                    r_mem[i] <= i_bulk_data[(i-1)*int'(KEY_LEN) +: KEY_LEN];
                end
            end
            if (i_rd_en) begin
                r_rd_data <= idx_in_range(i_rd_idx) ? r_mem[i_rd_idx] : '0;
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aes_key_ctrl.sv
// Sequences KeyExpantion for a loaded key and serves round keys by index.
// Optional AES_KEY_CTRL_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [KEY_LEN-1:0]               key_in,
    input  logic                             key_valid,
    output logic                             key_ready,
    output logic [KEY_LEN-1:0]               kex_key,
    output logic                             kex_valid,
    input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] kex_keys,
    input  logic [NUMS_OF_ROUND-1:0]         kex_valid_out,
    input  logic                             rk_req,
    input  logic [RK_IDX_W-1:0]              rk_idx,
    output logic [KEY_LEN-1:0]               rk_data,
    output logic                             rk_valid,
    output logic                             keys_ready,
    output logic                             err
`ifdef AES_KEY_CTRL_ZEROIZE_EN
    ,
    input  logic                             zeroize
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_key_ready;
    logic               r_kex_valid;
    logic [KEY_LEN-1:0] r_kex_key;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_seen_low;
    logic               r_keys_ready;
    logic               r_err;
    logic               r_rk_valid;

    logic w_zero;
    logic w_load;
    logic w_done;
    logic w_tmo;
    logic w_fetch;
    logic w_all_ones;
    logic w_clr;

`ifdef AES_KEY_CTRL_ZEROIZE_EN
    assign w_zero = zeroize;
    assign w_clr  = w_zero || w_tmo;
`else
    assign w_zero = 1'b0;
    assign w_clr  = 1'b0;
`endif

    assign w_all_ones = &kex_valid_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion needs a low valid_out first so a stale all-ones from the last run is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_fetch     = 1'b0;
        if (!w_zero) begin
            w_load = key_valid && r_key_ready;
        end
        case (r_state)
            IDLE, ERROR: begin
                if (w_load) w_state_nxt = EXPAND;
            end
            EXPAND: begin
                if (w_all_ones && r_seen_low) begin
                    w_done      = 1'b1;
                    w_state_nxt = READY;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ERROR;
                end
            end
            READY: begin
                if (w_load) begin
                    w_state_nxt = EXPAND;
                end else if (rk_req && !w_zero) begin
                    w_fetch = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_zero) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_ready  <= 1'b1;
            r_kex_valid  <= 1'b0;
            r_kex_key    <= '0;
            r_cnt        <= '0;
            r_seen_low   <= 1'b0;
            r_keys_ready <= 1'b0;
            r_err        <= 1'b0;
            r_rk_valid   <= 1'b0;
        end else begin
            r_key_ready <= (w_state_nxt != EXPAND);
            r_kex_valid <= (w_state_nxt == EXPAND);
            r_rk_valid  <= w_fetch;
            if (w_zero) begin
                r_kex_key <= '0;
            end else if (w_load) begin
                r_kex_key <= key_in;
            end
            if (w_load) begin
                r_cnt      <= '0;
                r_seen_low <= 1'b0;
            end else if (r_state == EXPAND) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (!w_all_ones) r_seen_low <= 1'b1;
            end
            if (w_zero || w_load) begin
                r_keys_ready <= 1'b0;
            end else if (w_done) begin
                r_keys_ready <= 1'b1;
            end
            if (w_load) begin
                r_err <= 1'b0;
            end else if (w_tmo || (w_fetch && !idx_in_range(rk_idx))) begin
                r_err <= 1'b1;
            end
        end
    end

    aes_rk_store u_store (
        .clk         (clk),
        .rst_n       (reset),
        .i_clr       (w_clr),
        .i_wr0_en    (w_load),
        .i_wr0_data  (key_in),
        .i_bulk_en   (w_done),
        .i_bulk_data (kex_keys),
        .i_rd_en     (w_fetch),
        .i_rd_idx    (rk_idx),
        .o_rd_data   (rk_data)
    );

    assign key_ready  = r_key_ready;
    assign kex_valid  = r_kex_valid;
    assign kex_key    = r_kex_key;
    assign keys_ready = r_keys_ready;
    assign err        = r_err;
    assign rk_valid   = r_rk_valid;

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Directed bench for aes_key_ctrl; KeyExpantion is replaced by bench-driven stub signals.
module tb_aes_key_ctrl;
    import aes_pkg::*;

    logic                             clk = 1'b0;
    logic                             reset;
    logic [KEY_LEN-1:0]               key_in;
    logic                             key_valid;
    logic                             key_ready;
    logic [KEY_LEN-1:0]               kex_key;
    logic                             kex_valid;
    logic [NUMS_OF_ROUND*KEY_LEN-1:0] kex_keys;
    logic [NUMS_OF_ROUND-1:0]         kex_valid_out;
    logic                             rk_req;
    logic [RK_IDX_W-1:0]              rk_idx;
    logic [KEY_LEN-1:0]               rk_data;
    logic                             rk_valid;
    logic                             keys_ready;
    logic                             err;
`ifdef AES_KEY_CTRL_ZEROIZE_EN
    logic                             zeroize;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [127:0] tab1 [0:10];
    logic [127:0] tab2 [0:10];
    logic [127:0] exp_hold;

    aes_key_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .kex_key       (kex_key),
        .kex_valid     (kex_valid),
        .kex_keys      (kex_keys),
        .kex_valid_out (kex_valid_out),
        .rk_req        (rk_req),
        .rk_idx        (rk_idx),
        .rk_data       (rk_data),
        .rk_valid      (rk_valid),
        .keys_ready    (keys_ready),
        .err           (err)
`ifdef AES_KEY_CTRL_ZEROIZE_EN
        ,
        .zeroize       (zeroize)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_keys(input int sel);
        for (int i = 0; i < 10; i++) begin
            kex_keys[i*128 +: 128] = (sel == 1) ? tab1[i+1] : tab2[i+1];
        end
    endtask

    task automatic load(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input int idx, input logic [127:0] exp);
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        @(negedge clk);
        rk_req = 1'b0;
        chk({tag, "_valid"}, 128'(rk_valid), 128'd1);
        chk({tag, "_data"}, rk_data, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 128'(rk_valid), 128'd0);
        chk({tag, "_hold"}, rk_data, exp);
    endtask

    initial begin
        tab1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        tab1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        tab1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        tab1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        tab1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        tab1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        tab1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        tab1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        tab1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        tab1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        tab1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 0; i <= 10; i++) tab2[i] = {16{8'(32'h20 + i)}};

        reset         = 1'b0;
        key_in        = '0;
        key_valid     = 1'b0;
        kex_keys      = '0;
        kex_valid_out = '0;
        rk_req        = 1'b0;
        rk_idx        = '0;
`ifdef AES_KEY_CTRL_ZEROIZE_EN
        zeroize       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_kex_valid", 128'(kex_valid), 128'd0);
        chk("rst_keys_ready", 128'(keys_ready), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk_data", rk_data, 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // First key: valid_out low on entry, rises after the first EXPAND cycle.
        set_keys(1);
        load(tab1[0]);
        chk("ld_kex_valid", 128'(kex_valid), 128'd1);
        chk("ld_key_ready", 128'(key_ready), 128'd0);
        chk("ld_kex_key", kex_key, tab1[0]);
        @(negedge clk);
        kex_valid_out = '1;
        chk("exp_not_done", 128'(keys_ready), 128'd0);
        @(negedge clk);
        chk("done_keys_ready", 128'(keys_ready), 128'd1);
        chk("done_kex_valid", 128'(kex_valid), 128'd0);
        chk("done_key_ready", 128'(key_ready), 128'd1);

        fetch("f0", 0, tab1[0]);
        fetch("f1", 1, tab1[1]);
        fetch("f10", 10, tab1[10]);

        // Back-to-back fetches, then an out-of-range index.
        for (int i = 0; i <= 10; i++) begin
            rk_req = 1'b1;
            rk_idx = 4'(i);
            @(negedge clk);
            chk($sformatf("b2b%0d_valid", i), 128'(rk_valid), 128'd1);
            chk($sformatf("b2b%0d_data", i), rk_data, tab1[i]);
        end
        rk_idx = 4'd11;
        @(negedge clk);
        rk_req = 1'b0;
        chk("oob_valid", 128'(rk_valid), 128'd1);
        chk("oob_data", rk_data, 128'd0);
        chk("oob_err", 128'(err), 128'd1);
        @(negedge clk);
        chk("oob_pulse", 128'(rk_valid), 128'd0);
        chk("oob_still_ready", 128'(keys_ready), 128'd1);

        // Reload with a simultaneous request; valid_out is still all-ones (stale).
        set_keys(2);
        key_in    = tab2[0];
        key_valid = 1'b1;
        rk_req    = 1'b1;
        rk_idx    = 4'd1;
        @(negedge clk);
        key_valid = 1'b0;
        rk_req    = 1'b0;
        chk("rl_no_rk_valid", 128'(rk_valid), 128'd0);
        chk("rl_keys_ready", 128'(keys_ready), 128'd0);
        chk("rl_err_clr", 128'(err), 128'd0);
        chk("rl_kex_valid", 128'(kex_valid), 128'd1);
        repeat (3) @(negedge clk);
        chk("stale_ignored", 128'(keys_ready), 128'd0);
        kex_valid_out = '0;
        @(negedge clk);
        kex_valid_out = '1;
        chk("stale_low", 128'(keys_ready), 128'd0);
        @(negedge clk);
        chk("stale_rise", 128'(keys_ready), 128'd1);
        fetch("r1", 1, tab2[1]);
        fetch("r0", 0, tab2[0]);
        fetch("r10", 10, tab2[10]);

        // Timeout: valid_out never completes.
        kex_valid_out = '0;
        load(tab1[0]);
        repeat (63) @(negedge clk);
        chk("tmo_63_err", 128'(err), 128'd0);
        chk("tmo_63_kex_valid", 128'(kex_valid), 128'd1);
        @(negedge clk);
        chk("tmo_err", 128'(err), 128'd1);
        chk("tmo_kex_valid", 128'(kex_valid), 128'd0);
        chk("tmo_key_ready", 128'(key_ready), 128'd1);
        chk("tmo_keys_ready", 128'(keys_ready), 128'd0);
`ifdef AES_KEY_CTRL_ZEROIZE_EN
        exp_hold = 128'd0;
`else
        exp_hold = tab2[10];
`endif
        rk_req = 1'b1;
        rk_idx = 4'd0;
        @(negedge clk);
        rk_req = 1'b0;
        chk("err_req_ignored", 128'(rk_valid), 128'd0);
        chk("err_rk_hold", rk_data, exp_hold);

        // Reset in the middle of an expansion.
        load(tab1[0]);
        repeat (2) @(negedge clk);
        chk("pre_rst_kex_valid", 128'(kex_valid), 128'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_kex_valid", 128'(kex_valid), 128'd0);
        chk("mid_rst_keys_ready", 128'(keys_ready), 128'd0);
        chk("mid_rst_err", 128'(err), 128'd0);
        chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
        chk("mid_rst_rk_data", rk_data, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef AES_KEY_CTRL_ZEROIZE_EN
        // Zeroize from READY wipes key material.
        set_keys(1);
        kex_valid_out = '0;
        load(tab1[0]);
        @(negedge clk);
        kex_valid_out = '1;
        @(negedge clk);
        fetch("z_pre", 1, tab1[1]);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("z_keys_ready", 128'(keys_ready), 128'd0);
        chk("z_rk_data", rk_data, 128'd0);
        chk("z_kex_key", kex_key, 128'd0);
        chk("z_key_ready", 128'(key_ready), 128'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_ctrl.md
Name: aes_key_ctrl

Overview:
Sequencing controller for the KeyExpantion block in the AES datapath. It accepts a secret-key load through a valid/ready handshake and drives KeyExpantion until all round keys are valid. It then captures the original key plus NUMS_OF_ROUND expanded keys into a local round-key store. An iterative cipher core fetches keys from that store by round index, one request per cycle.

Parameters:
- KEY_LEN, 128: key and round-key width.
- NUMS_OF_ROUND, 10: expanded round keys produced by KeyExpantion.
- TIMEOUT_CYC, 64: maximum cycles allowed in EXPAND before ERROR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_in  in  KEY_LEN  secret key to load.
- key_valid  in  1  load request.
- key_ready  out  1  load can be accepted.
- kex_key  out  KEY_LEN  drives KeyExpantion Secret_key.
- kex_valid  out  1  drives KeyExpantion valid_in.
- kex_keys  in  NUMS_OF_ROUND*KEY_LEN  KeyExpantion key_expan; slice i = expanded round i+1.
- kex_valid_out  in  NUMS_OF_ROUND  KeyExpantion valid_out.
- rk_req  in  1  round-key fetch request.
- rk_idx  in  4  round index 0..NUMS_OF_ROUND; 0 = original key.
- rk_data  out  KEY_LEN  fetched round key.
- rk_valid  out  1  rk_data valid, one-cycle pulse.
- keys_ready  out  1  store holds a complete schedule.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except key_ready=1.
  - Store, timeout counter and edge-seen flag cleared.
  - Reset during EXPAND aborts the expansion; kex_valid drops immediately.
- States: IDLE, EXPAND, READY, ERROR.
- key_ready=1 in IDLE, READY and ERROR; 0 in EXPAND.
- Load acceptance: key_valid&&key_ready on a clock edge.
  - Latch key_in into kex_key and store[0].
  - keys_ready<=0, err<=0, counter<=0, seen_low<=0.
  - Go to EXPAND.
- EXPAND:
  - kex_valid=1 for the whole state.
  - seen_low is set on any cycle where &kex_valid_out==0.
  - Completion = &kex_valid_out==1 with seen_low already set, so stale all-ones from a previous run is ignored.
  - On completion: store[1..NUMS_OF_ROUND] <= kex_keys slices; kex_valid<=0; keys_ready<=1; go to READY.
  - Counter increments every EXPAND cycle. If it reaches TIMEOUT_CYC without completion: kex_valid<=0, err<=1, go to ERROR. Completion and timeout on the same edge: completion wins.
- READY, fetch:
  - rk_req with rk_idx<=NUMS_OF_ROUND gives rk_valid=1 and rk_data=store[rk_idx] on the next cycle (latency 1).
  - Back-to-back requests are supported, one per cycle.
  - rk_idx>NUMS_OF_ROUND gives rk_valid=1, rk_data=0 and sets err (state stays READY).
- rk_req in IDLE, EXPAND or ERROR is ignored: rk_valid=0, rk_data holds its previous value.
- A load accepted in the same cycle as rk_req: the load wins and the request is dropped.
- A new load from READY invalidates the schedule: keys_ready falls the cycle after acceptance.
- ERROR: exited only by a new load or by reset.
- rk_data holds its value between pulses.

Optional Feature:
- Macro: AES_KEY_CTRL_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - A zeroize pulse clears every store entry, rk_data and kex_key to 0, drops keys_ready and goes to IDLE. Active in any state.
  - Entering ERROR also clears the store.
  - zeroize has priority over a simultaneous load.
- Not defined: no zeroize port; the store keeps its contents until overwritten or reset.

Decomposition:
- Package aes_pkg:
  - KEY_LEN and NUMS_OF_ROUND constants.
  - RK_IDX_W=4.
  - State enum typedef (IDLE/EXPAND/READY/ERROR).
  - Round-key typedef logic[KEY_LEN-1:0].
- Sub-module aes_rk_store: (NUMS_OF_ROUND+1)-entry register file with a single-entry write for index 0, a bulk write for 1..N, a registered read port and a clear input.
- The FSM, handshake and timeout counter stay in aes_key_ctrl.

Test Plan:
- Load 000102030405060708090a0b0c0d0e0f with the real KeyExpantion attached, wait for keys_ready, then fetch:
  - idx0 -> 000102030405060708090a0b0c0d0e0f.
  - idx1 -> d6aa74fdd2af72fadaa678f1d6ab76fe.
  - idx10 -> 13111d7fe3944a17f307a78b4d2b30c5.
  - Each fetch: rk_valid exactly 1 cycle after rk_req.
- Back-to-back fetches idx 0..10 on consecutive cycles -> 11 consecutive rk_valid pulses, correct data in order; then rk_idx=11 -> rk_data=0 and err=1.
- Stub KeyExpantion with kex_valid_out stuck at 0 -> after 64 EXPAND cycles: state ERROR, err=1, kex_valid=0, key_ready=1.
- Stub with valid_out already all-ones at entry -> no completion until it drops and rises again; keys_ready timing matches the rising edge +1.
- Reload a second key while READY with a simultaneous rk_req -> no rk_valid; keys_ready=0 next cycle; new schedule fetched correctly afterwards.
- Assert reset mid-EXPAND -> kex_valid, keys_ready and err all 0 immediately; with AES_KEY_CTRL_ZEROIZE_EN, a zeroize pulse in READY -> keys_ready=0 and the store reads all zero after the next load's idx1 is overwritten.
